// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and instruction field widths.
package cpu_pkg;
  localparam int XLEN     = 32;
  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out, ack/data back.
interface fetch_unit_if;
  import cpu_pkg::*;
  logic               mem_req_o;
  logic [XLEN-1:0]    mem_addr_o;
  logic               mem_ack_i;
  logic [INSTR_W-1:0] mem_rdata_i;

  modport master (output mem_req_o, mem_addr_o, input mem_ack_i, mem_rdata_i);
  modport slave  (input mem_req_o, mem_addr_o, output mem_ack_i, mem_rdata_i);
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter for an outstanding fetch; flags the last allowed cycle.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  // Count only reaches TIMEOUT-1: that value marks the final REQ cycle.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  // Next count: clear wins, increment saturates at the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request word at pc, present it,
// advance pc when downstream releases it. Timeout/misalignment latch err.
module fetch_unit import cpu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              TIMEOUT  = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  fetch_unit_if.master        mem,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [OPCODE_W-1:0] opcode_o,
  output logic [XLEN-1:0]     pc_o,
  output logic                instr_valid_o,
  output logic                err_o
);
  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               req_q, vld_q, err_q;
  logic               tmo_clr, tmo_en, tmo_expired;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

  // Next state and datapath; ack is only looked at while requesting.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      ST_IDLE:  state_d = (pc_q[1:0] != 2'b00) ? ST_ERR : ST_REQ;
      ST_REQ: begin
        if (mem.mem_ack_i) begin
          instr_d = mem.mem_rdata_i;
          state_d = ST_VALID;
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_VALID: begin
        if (!stall_i) begin
          pc_d    = pc_q + 32'd4;  // wraps naturally at 2^32
          state_d = ST_REQ;
        end
      end
      ST_ERR:   state_d = ST_ERR;
      default:  state_d = ST_ERR;
    endcase
  end

  assign tmo_clr = (state_d == ST_REQ) && (state_q != ST_REQ);
  assign tmo_en  = (state_q == ST_REQ) && !mem.mem_ack_i;

  // State, pc, instruction and per-state output flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= (state_d == ST_REQ);
      vld_q   <= (state_d == ST_VALID);
      err_q   <= (state_d == ST_ERR);
    end
  end

  // Bubbles present a zero opcode so the decoder issues no writes.
  assign opcode_o       = vld_q ? instr_q[OPCODE_W-1:0] : '0;
  assign mem.mem_addr_o = pc_q;
  assign mem.mem_req_o  = req_q;
  assign instr_o        = instr_q;
  assign pc_o           = pc_q;
  assign instr_valid_o  = vld_q;
  assign err_o          = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three instances (aligned, wrapping, misaligned reset
// pc) share one random stimulus stream and are compared each cycle against
// a transaction-level model of the fetch rules.
module tb_fetch_unit;
  localparam int TMO = 15;
  localparam logic [2:0][31:0] RST_PC = {32'h0000_0002, 32'hFFFF_FFFC, 32'h0000_0000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic ack = 1'b0;
  logic [31:0] rdata = '0;

  always #5 clk = ~clk;

  fetch_unit_if mif0 ();
  fetch_unit_if mif1 ();
  fetch_unit_if mif2 ();

  assign mif0.mem_ack_i = ack;  assign mif0.mem_rdata_i = rdata;
  assign mif1.mem_ack_i = ack;  assign mif1.mem_rdata_i = rdata;
  assign mif2.mem_ack_i = ack;  assign mif2.mem_rdata_i = rdata;

  logic [2:0][31:0] instr_w, pc_w, addr_w;
  logic [2:0][6:0]  opc_w;
  logic [2:0]       vld_w, err_w, req_w;

  assign req_w[0] = mif0.mem_req_o;  assign addr_w[0] = mif0.mem_addr_o;
  assign req_w[1] = mif1.mem_req_o;  assign addr_w[1] = mif1.mem_addr_o;
  assign req_w[2] = mif2.mem_req_o;  assign addr_w[2] = mif2.mem_addr_o;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TMO)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .mem(mif0),
    .instr_o(instr_w[0]), .opcode_o(opc_w[0]), .pc_o(pc_w[0]),
    .instr_valid_o(vld_w[0]), .err_o(err_w[0]));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(TMO)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .mem(mif1),
    .instr_o(instr_w[1]), .opcode_o(opc_w[1]), .pc_o(pc_w[1]),
    .instr_valid_o(vld_w[1]), .err_o(err_w[1]));
  fetch_unit #(.RESET_PC(32'h0000_0002), .TIMEOUT(TMO)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .mem(mif2),
    .instr_o(instr_w[2]), .opcode_o(opc_w[2]), .pc_o(pc_w[2]),
    .instr_valid_o(vld_w[2]), .err_o(err_w[2]));

  int n_chk = 0;
  int n_err = 0;
  bit saw_req2 = 1'b0;

  always @(negedge clk) if (req_w[2] === 1'b1) saw_req2 = 1'b1;

  // Reference model: per instance, the fetch address, the held word, whether
  // a word is presented, how long the current request has waited, and error.
  logic [31:0] m_pc    [3];
  logic [31:0] m_instr [3];
  bit          m_valid [3];
  bit          m_err   [3];
  bit          m_start [3];
  int          m_waits [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_pc[i] = RST_PC[i]; m_instr[i] = '0; m_valid[i] = 0;
    m_err[i] = 0; m_start[i] = 0; m_waits[i] = 0;
  endtask

  task automatic model_step(input int i);
    if (!m_start[i]) begin
      m_start[i] = 1;
      if (m_pc[i] % 4 != 0) m_err[i] = 1;
    end else if (m_err[i]) begin
    end else if (!m_valid[i]) begin
      if (ack) begin
        m_instr[i] = rdata; m_valid[i] = 1; m_waits[i] = 0;
      end else begin
        m_waits[i]++;
        if (m_waits[i] == TMO) m_err[i] = 1;
      end
    end else if (!stall) begin
      m_valid[i] = 0; m_pc[i] = m_pc[i] + 32'd4; m_waits[i] = 0;
    end
  endtask

  task automatic check_all(input int i);
    logic [31:0] exp_opc;
    exp_opc = m_valid[i] ? {25'd0, m_instr[i][6:0]} : 32'd0;
    chk($sformatf("d%0d.pc", i),    pc_w[i],    m_pc[i]);
    chk($sformatf("d%0d.addr", i),  addr_w[i],  m_pc[i]);
    chk($sformatf("d%0d.instr", i), instr_w[i], m_instr[i]);
    chk($sformatf("d%0d.valid", i), {31'd0, vld_w[i]}, {31'd0, m_valid[i]});
    chk($sformatf("d%0d.err", i),   {31'd0, err_w[i]}, {31'd0, m_err[i]});
    chk($sformatf("d%0d.req", i),   {31'd0, req_w[i]},
        {31'd0, (m_start[i] && !m_err[i] && !m_valid[i])});
    chk($sformatf("d%0d.opcode", i), {25'd0, opc_w[i]}, exp_opc);
  endtask

  // One clock: drive at negedge, step model at posedge, check at negedge.
  task automatic cyc(input bit s, input bit a, input logic [31:0] d);
    stall = s; ack = a; rdata = d;
    @(posedge clk);
    if (!rst) for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_all(i);
  endtask

  // Asynchronous reset pulse starting at a negedge; outputs checked at once.
  task automatic do_reset();
    rst = 1'b1; ack = 1'b0; stall = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin model_reset(i); check_all(i); end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_all(i);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_pct [5] = '{50, 30, 90, 0, 10};
    logic [31:0] held_instr;

    @(negedge clk);
    do_reset();
    chk("rst.pc0", pc_w[0], 32'h0);
    chk("rst.req0", {31'd0, req_w[0]}, 32'd0);

    // First fetch: idle cycle, then ack in the first request cycle.
    cyc(0, 1, 32'hAAAA_AAAA);            // IDLE -> REQ, ack ignored
    chk("first.req", {31'd0, req_w[0]}, 32'd1);
    chk("first.instr_untouched", instr_w[0], 32'h0);
    cyc(0, 1, 32'h0050_0093);
    chk("first.valid", {31'd0, vld_w[0]}, 32'd1);
    chk("first.opcode", {25'd0, opc_w[0]}, 32'h13);
    chk("first.pc", pc_w[0], 32'h0);
    chk("first.req_low", {31'd0, req_w[0]}, 32'd0);

    // Back-to-back fetches: request every other cycle, pc 4 then 8.
    cyc(0, 0, 32'h0);
    chk("b2b.pc4", pc_w[0], 32'h4);
    chk("b2b.req4", {31'd0, req_w[0]}, 32'd1);
    chk("wrap.addr0", addr_w[1], 32'h0);
    chk("wrap.err", {31'd0, err_w[1]}, 32'd0);
    cyc(0, 1, 32'h0000_0113);
    chk("b2b.noreq", {31'd0, req_w[0]}, 32'd0);
    cyc(0, 0, 32'h0);
    chk("b2b.pc8", pc_w[0], 32'h8);
    chk("b2b.req8", {31'd0, req_w[0]}, 32'd1);
    cyc(0, 1, 32'h0000_0213);

    // Stall for five cycles with stray acks: nothing moves.
    held_instr = instr_w[0];
    for (int k = 0; k < 5; k++) begin
      cyc(1, k[0], $urandom);
      chk("stall.instr", instr_w[0], 32'h0000_0213);
      chk("stall.pc", pc_w[0], 32'h8);
      chk("stall.req", {31'd0, req_w[0]}, 32'd0);
    end
    chk("stall.held", instr_w[0], held_instr);

    // Timeout: fifteen request cycles without ack.
    do_reset();
    cyc(0, 0, 32'h0);
    for (int k = 0; k < TMO; k++) cyc(0, 0, 32'h0);
    chk("tmo.err", {31'd0, err_w[0]}, 32'd1);
    chk("tmo.req", {31'd0, req_w[0]}, 32'd0);
    cyc(0, 1, 32'h0000_0013);
    chk("tmo.sticky", {31'd0, err_w[0]}, 32'd1);
    chk("tmo.opcode", {25'd0, opc_w[0]}, 32'd0);

    // Ack on the fifteenth request cycle still wins.
    do_reset();
    cyc(0, 0, 32'h0);
    for (int k = 0; k < TMO - 1; k++) cyc(0, 0, 32'h0);
    cyc(0, 1, 32'h0000_0033);
    chk("tmo15.valid", {31'd0, vld_w[0]}, 32'd1);
    chk("tmo15.err", {31'd0, err_w[0]}, 32'd0);

    // Reset mid-request, stale ack right after release is ignored.
    do_reset();
    cyc(0, 0, 32'h0);
    cyc(0, 0, 32'h0);
    do_reset();
    cyc(0, 1, 32'hDEAD_BEEF);
    chk("stale.valid", {31'd0, vld_w[0]}, 32'd0);
    chk("stale.instr", instr_w[0], 32'h0);
    chk("stale.pc", pc_w[0], 32'h0);

    // Randomized segments with varying memory responsiveness.
    for (int seg = 0; seg < 5; seg++) begin
      do_reset();
      for (int k = 0; k < 300; k++)
        cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 99) < ack_pct[seg]), $urandom);
    end

    chk("misaligned.err", {31'd0, err_w[2]}, 32'd1);
    chk("misaligned.never_req", {31'd0, saw_req2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
